// File: rtl/decode_sequencer_if.sv
// decode_sequencer_if: fetch-side inputs and control-unit-side outputs of the decode sequencer
interface decode_sequencer_if #(parameter int WORD_W = 16, parameter int OPC_W = 5);
  logic [WORD_W-1:0] instrIn;
  logic              stall;
  logic              flush;
  logic              intReq;
  logic [OPC_W-1:0]  opCode;
  logic [2:0]        rdst;
  logic [2:0]        rsrc;
  logic [4:0]        shamt;
  logic [WORD_W-1:0] immOut;
  logic              immValid;
  logic              makeMeBubble;
  logic              pcHold;
  logic              intAck;
  modport master (
    output instrIn, stall, flush, intReq,
    input  opCode, rdst, rsrc, shamt, immOut, immValid, makeMeBubble, pcHold, intAck
  );
  modport slave (
    input  instrIn, stall, flush, intReq,
    output opCode, rdst, rsrc, shamt, immOut, immValid, makeMeBubble, pcHold, intAck
  );
endinterface

// File: rtl/decode_sequencer.sv
// decode_sequencer: IF/ID instruction register, field split and two-phase expansion of LDM/CALL/RET/RTI/interrupt
module decode_sequencer #(
  parameter int WORD_W = 16,
  parameter int OPC_W  = 5
) (
  input logic           clk,
  input logic           rst,
  decode_sequencer_if.slave bus
);
  typedef enum logic [2:0] {NORMAL, LDM_IMM, CALL2, RET2, RTI2, INT1, INT2} state_t;
  localparam logic [OPC_W-1:0] OP_NOP  = '0;
  localparam logic [OPC_W-1:0] OP_LDM  = OPC_W'(5'b10001);
  localparam logic [OPC_W-1:0] OP_CALL = OPC_W'(5'b11000);
  localparam logic [OPC_W-1:0] OP_RET  = OPC_W'(5'b11010);
  localparam logic [OPC_W-1:0] OP_RTI  = OPC_W'(5'b11100);
  localparam logic [OPC_W-1:0] OP_INT  = OPC_W'(5'b11110);
  state_t            state_q;
  logic              int_req_q, int_pend_q, flush_pend_q;
  logic [OPC_W-1:0]  opc_q;
  logic [2:0]        rdst_q, rsrc_q;
  logic [4:0]        shamt_q;
  logic [WORD_W-1:0] imm_q;
  logic              imm_v_q, bubble_q, ack_q;
  logic [OPC_W-1:0]  op;
  logic              f, sec, kill, hold, multi, illegal;
  assign op      = bus.instrIn[WORD_W-1 -: OPC_W];
  assign f       = bus.flush | flush_pend_q;
  assign sec     = state_q == INT1 || state_q == CALL2;
  assign kill    = f & ~sec;
  assign hold    = bus.stall & ~f;
  assign multi   = op inside {OP_CALL, OP_RET, OP_RTI};
  assign illegal = op inside {OPC_W'(5'b11001), OPC_W'(5'b11011), OPC_W'(5'b11101), OPC_W'(5'b11110), OPC_W'(5'b11111)};
  assign bus.pcHold = state_q == INT1 || (~f && (bus.stall || (state_q == NORMAL && (int_pend_q || multi))));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= NORMAL;
      int_req_q    <= 1'b0;
      int_pend_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      opc_q        <= OP_NOP;
      rdst_q       <= '0;
      rsrc_q       <= '0;
      shamt_q      <= '0;
      imm_q        <= '0;
      imm_v_q      <= 1'b0;
      bubble_q     <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      int_req_q    <= bus.intReq;
      int_pend_q   <= (bus.intReq & ~int_req_q) | (int_pend_q & ~(state_q == INT1 && !hold));
      flush_pend_q <= f & sec;
      bubble_q     <= 1'b0;
      ack_q        <= 1'b0;
      if (kill) begin
        state_q <= NORMAL;
        opc_q   <= OP_NOP;
        imm_v_q <= 1'b0;
      end else if (hold) begin
        bubble_q <= 1'b1;
      end else begin
        imm_v_q <= 1'b0;
        case (state_q)
          NORMAL: begin
            if (int_pend_q) begin
              opc_q   <= OP_INT;
              state_q <= INT1;
            end else begin
              opc_q   <= (op == OP_LDM || illegal) ? OP_NOP : op;
              rdst_q  <= bus.instrIn[10:8];
              rsrc_q  <= bus.instrIn[7:5];
              shamt_q <= bus.instrIn[4:0];
              state_q <= op == OP_LDM  ? LDM_IMM :
                         op == OP_CALL ? CALL2 :
                         op == OP_RET  ? RET2 :
                         op == OP_RTI  ? RTI2 : NORMAL;
            end
          end
          LDM_IMM: begin
            opc_q   <= OP_LDM;
            imm_q   <= bus.instrIn;
            imm_v_q <= 1'b1;
            state_q <= NORMAL;
          end
          CALL2, RET2, RTI2, INT1: begin
            // every second-phase opcode is its first-phase opcode with the LSB set
            opc_q   <= opc_q | OPC_W'(1);
            ack_q   <= state_q == INT1;
            state_q <= NORMAL;
          end
          default: state_q <= NORMAL;
        endcase
      end
    end
  end
  assign bus.opCode       = opc_q;
  assign bus.rdst         = rdst_q;
  assign bus.rsrc         = rsrc_q;
  assign bus.shamt        = shamt_q;
  assign bus.immOut       = imm_q;
  assign bus.immValid     = imm_v_q;
  assign bus.makeMeBubble = bubble_q;
  assign bus.intAck       = ack_q;
endmodule

// File: tb/tb_decode_sequencer.sv
// tb_decode_sequencer: directed steps with a scoreboard queue of expected registered outputs
module tb_decode_sequencer;
  typedef struct packed {
    logic [4:0]  opc;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic        iv;
    logic        bub;
    logic        ack;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int n_step = 0;
  exp_t q[$];
  decode_sequencer_if ifc();
  decode_sequencer dut (.clk(clk), .rst(rst), .bus(ifc));
  always #5 clk = ~clk;
  function automatic logic [15:0] w(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [4:0] sh);
    return {op, rd, rs, sh};
  endfunction
  task automatic step(input logic r, input logic [15:0] word, input logic st, input logic fl, input logic ir,
                      input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [4:0] sh,
                      input logic [15:0] im, input logic iv, input logic bub, input logic ack, input logic pc);
    exp_t e, got;
    n_step++;
    rst = r;
    ifc.instrIn = word;
    ifc.stall = st;
    ifc.flush = fl;
    ifc.intReq = ir;
    #1;
    n_cmp++;
    assert (ifc.pcHold === pc) else begin
      n_bad++;
      $error("FAIL pcHold step %0d: got %b want %b", n_step, ifc.pcHold, pc);
    end
    q.push_back({op, rd, rs, sh, im, iv, bub, ack});
    @(posedge clk);
    #1;
    e = q.pop_front();
    got = {ifc.opCode, ifc.rdst, ifc.rsrc, ifc.shamt, ifc.immOut, ifc.immValid, ifc.makeMeBubble, ifc.intAck};
    n_cmp++;
    assert (got === e) else begin
      n_bad++;
      $error("FAIL outputs step %0d: got opc=%b rd=%0d rs=%0d sh=%0d imm=%h iv=%b bub=%b ack=%b want opc=%b rd=%0d rs=%0d sh=%0d imm=%h iv=%b bub=%b ack=%b",
             n_step, got.opc, got.rd, got.rs, got.sh, got.imm, got.iv, got.bub, got.ack,
             e.opc, e.rd, e.rs, e.sh, e.imm, e.iv, e.bub, e.ack);
    end
  endtask
  initial begin
    ifc.instrIn = '0;
    ifc.stall = 1'b0;
    ifc.flush = 1'b0;
    ifc.intReq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(1, 16'hFFFF, 0, 0, 0, 5'b00000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    step(0, w(5'b01001, 1, 2, 3), 0, 0, 0, 5'b01001, 1, 2, 3, 16'h0000, 0, 0, 0, 0);
    step(0, w(5'b00100, 4, 5, 6), 0, 0, 0, 5'b00100, 4, 5, 6, 16'h0000, 0, 0, 0, 0);
    step(0, w(5'b00000, 7, 0, 1), 0, 0, 0, 5'b00000, 7, 0, 1, 16'h0000, 0, 0, 0, 0);
    step(0, 16'h8900, 0, 0, 0, 5'b00000, 1, 0, 0, 16'h0000, 0, 0, 0, 0);
    step(0, 16'h1234, 0, 0, 0, 5'b10001, 1, 0, 0, 16'h1234, 1, 0, 0, 0);
    step(0, w(5'b01001, 2, 3, 4), 0, 0, 0, 5'b01001, 2, 3, 4, 16'h1234, 0, 0, 0, 0);
    step(0, 16'hC000, 0, 0, 0, 5'b11000, 0, 0, 0, 16'h1234, 0, 0, 0, 1);
    step(0, 16'hC000, 0, 0, 0, 5'b11001, 0, 0, 0, 16'h1234, 0, 0, 0, 0);
    step(0, w(5'b00010, 1, 1, 1), 0, 0, 1, 5'b00010, 1, 1, 1, 16'h1234, 0, 0, 0, 0);
    step(0, w(5'b00011, 2, 2, 2), 0, 0, 1, 5'b11110, 1, 1, 1, 16'h1234, 0, 0, 0, 1);
    step(0, w(5'b00011, 2, 2, 2), 0, 0, 1, 5'b11111, 1, 1, 1, 16'h1234, 0, 0, 1, 1);
    step(0, w(5'b00011, 2, 2, 2), 0, 0, 1, 5'b00011, 2, 2, 2, 16'h1234, 0, 0, 0, 0);
    step(0, w(5'b00100, 3, 3, 3), 0, 0, 0, 5'b00100, 3, 3, 3, 16'h1234, 0, 0, 0, 0);
    step(0, w(5'b00010, 4, 4, 4), 0, 0, 0, 5'b00010, 4, 4, 4, 16'h1234, 0, 0, 0, 0);
    step(0, w(5'b00010, 5, 5, 5), 1, 0, 0, 5'b00010, 4, 4, 4, 16'h1234, 0, 1, 0, 1);
    step(0, w(5'b00010, 5, 5, 5), 1, 0, 0, 5'b00010, 4, 4, 4, 16'h1234, 0, 1, 0, 1);
    step(0, w(5'b00010, 5, 5, 5), 0, 0, 0, 5'b00010, 5, 5, 5, 16'h1234, 0, 0, 0, 0);
    step(0, 16'h8E00, 0, 0, 0, 5'b00000, 6, 0, 0, 16'h1234, 0, 0, 0, 0);
    step(0, 16'h5555, 0, 1, 0, 5'b00000, 6, 0, 0, 16'h1234, 0, 0, 0, 0);
    step(0, w(5'b00100, 1, 2, 3), 0, 0, 0, 5'b00100, 1, 2, 3, 16'h1234, 0, 0, 0, 0);
    step(0, w(5'b11000, 3, 4, 5), 0, 0, 0, 5'b11000, 3, 4, 5, 16'h1234, 0, 0, 0, 1);
    step(0, w(5'b11000, 3, 4, 5), 0, 1, 0, 5'b11001, 3, 4, 5, 16'h1234, 0, 0, 0, 0);
    step(0, w(5'b00010, 7, 7, 7), 0, 0, 0, 5'b00000, 3, 4, 5, 16'h1234, 0, 0, 0, 0);
    step(0, w(5'b00010, 7, 7, 7), 0, 0, 0, 5'b00010, 7, 7, 7, 16'h1234, 0, 0, 0, 0);
    step(0, w(5'b11010, 1, 0, 0), 0, 0, 0, 5'b11010, 1, 0, 0, 16'h1234, 0, 0, 0, 1);
    step(0, w(5'b11010, 1, 0, 0), 0, 0, 0, 5'b11011, 1, 0, 0, 16'h1234, 0, 0, 0, 0);
    step(0, w(5'b11100, 2, 1, 0), 0, 0, 0, 5'b11100, 2, 1, 0, 16'h1234, 0, 0, 0, 1);
    step(0, w(5'b11100, 2, 1, 0), 0, 0, 0, 5'b11101, 2, 1, 0, 16'h1234, 0, 0, 0, 0);
    step(0, w(5'b11111, 2, 2, 2), 0, 0, 0, 5'b00000, 2, 2, 2, 16'h1234, 0, 0, 0, 0);
    step(0, w(5'b00001, 1, 1, 1), 0, 0, 0, 5'b00001, 1, 1, 1, 16'h1234, 0, 0, 0, 0);
    step(0, w(5'b00101, 3, 3, 3), 1, 1, 0, 5'b00000, 1, 1, 1, 16'h1234, 0, 0, 0, 0);
    step(0, 16'h8900, 0, 0, 0, 5'b00000, 1, 0, 0, 16'h1234, 0, 0, 0, 0);
    step(1, 16'h1234, 0, 0, 0, 5'b00000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    step(0, w(5'b01001, 1, 2, 3), 0, 0, 0, 5'b01001, 1, 2, 3, 16'h0000, 0, 0, 0, 0);
    step(0, w(5'b00001, 0, 0, 0), 0, 0, 1, 5'b00001, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    step(0, w(5'b00110, 1, 1, 1), 0, 1, 1, 5'b00000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    step(0, w(5'b00110, 1, 1, 1), 0, 0, 0, 5'b11110, 0, 0, 0, 16'h0000, 0, 0, 0, 1);
    step(0, w(5'b00110, 1, 1, 1), 0, 0, 0, 5'b11111, 0, 0, 0, 16'h0000, 0, 0, 1, 1);
    step(0, w(5'b00110, 1, 1, 1), 0, 0, 0, 5'b00110, 1, 1, 1, 16'h0000, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_sequencer.md
Name: decode_sequencer

Overview:
- Sits between instruction memory and the control unit, in the IF/ID boundary.
- Registers the fetched word and splits it into fields.
- Presents the 5-bit opcode the control unit decodes.
- Expands multi-cycle instructions into their two control phases: LDM, CALL, RET, RTI, and hardware interrupt entry.
- Produces the fetch-freeze and bubble signals that keep PC and the control unit consistent.

Parameters:
WORD_W, 16, instruction/immediate word width
OPC_W, 5, opcode width (bits [WORD_W-1 -: OPC_W])

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
instrIn  in  WORD_W  word from instruction memory at current PC
stall  in  1  load-use hazard from hazard unit; hold current decode
flush  in  1  taken branch/jump resolved in EX; kill decode contents
intReq  in  1  external interrupt request, level
opCode  out  OPC_W  opcode to control unit
rdst  out  3  instrIn[10:8] of the issuing instruction
rsrc  out  3  instrIn[7:5]
shamt  out  5  instrIn[4:0]
immOut  out  WORD_W  immediate word for LDM
immValid  out  1  immOut valid this cycle
makeMeBubble  out  1  to control unit; forces bubble
pcHold  out  1  freeze PC/fetch this cycle
intAck  out  1  one-cycle interrupt acknowledge

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high (polarity and synchronicity fixed).
- Output registers: all outputs except pcHold are registered; latency from instrIn to opCode is 1 cycle.
- pcHold is combinational from state, stall and the decoded instrIn opcode.
- Reset: state=NORMAL, intPending=0, and all outputs 0 (opCode=00000 is NOP, makeMeBubble=0, immOut=0).
- Interrupt latch: intPending is set on an intReq rising edge (sampled intReq vs. a registered copy). It is cleared when opcode 11111 issues.

FSM states: NORMAL, LDM_IMM, CALL2, RET2, RTI2, INT1, INT2.

- NORMAL
  - If intPending, no stall, no flush: issue 11110, pcHold=1, go to INT1. The fetched word is discarded and refetched later.
  - Else decode instrIn[15:11]:
    - 10001 (LDM): issue 00000, latch rdst, go to LDM_IMM.
    - 11000: issue 11000, pcHold=1, go to CALL2.
    - 11010: issue 11010, pcHold=1, go to RET2.
    - 11100: issue 11100, pcHold=1, go to RTI2.
    - 11001, 11011, 11101, 11110, 11111 arriving from memory are illegal and issue 00000.
    - Any other opcode: issue it with its fields, stay in NORMAL.
- LDM_IMM: issue 10001 with latched rdst, immOut=instrIn, immValid=1; go to NORMAL.
- CALL2: issue 11001, go to NORMAL.
- RET2: issue 11011, go to NORMAL.
- RTI2: issue 11101, go to NORMAL.
  - Second phases reuse the latched rdst/rsrc.
- INT1: issue 11111, intAck=1, clear intPending, pcHold=1, go to NORMAL.
- stall=1: all output registers and state hold; makeMeBubble=1 registered for that cycle; pcHold=1. Stall has priority over interrupt entry but not over flush.
- flush=1: next opCode=00000, immValid=0, makeMeBubble=0; state goes to NORMAL.
  - Exception: a flush during INT1 or CALL2 is ignored, since second phases must complete. The flush is then applied on the next cycle.
  - An interrupt pending during a flush stays pending.
- Simultaneous stall+flush: flush wins.
- Interrupt during LDM_IMM, CALL2, RET2 or RTI2: deferred until NORMAL.
- rst mid-sequence: state returns to NORMAL, the partial sequence is dropped, intPending is cleared.
- Field extraction is pure bit-select; no arithmetic.

Test Plan:
- Reset then stream of three words with opcodes 01001, 00100, 00000 -> opCode shows 01001, 00100, 00000 one cycle after each word; pcHold=0, makeMeBubble=0.
- LDM word 0x8900 (rdst=1) followed by 0x1234 -> cycle1 opCode=00000; cycle2 opCode=10001, rdst=1, immOut=0x1234, immValid=1 for exactly one cycle.
- CALL word 0xC000 -> opCode 11000 then 11001 on consecutive cycles; pcHold=1 only during the first.
- intReq pulse while an ADD is executing -> next NORMAL cycle issues 11110 then 11111; intAck=1 coincident with 11111; a second intReq held high produces no repeat.
- stall=1 for 2 cycles during an ADD stream -> opCode frozen, makeMeBubble=1 both cycles, pcHold=1; resumes correctly.
- flush=1 in LDM_IMM -> opCode=00000, immValid=0, state NORMAL. flush=1 in CALL2 -> 11001 still issued, 00000 next cycle.
